instr_mem_responder: RTL
========================

# instr_mem_responder

Responder side of the instruction-fetch interface: accepts 30-bit word addresses from the fetch unit over a valid/ready request channel, reads a program memory after a fixed number of wait states, and returns the 32-bit instruction word over a valid/ready response channel. A side load port writes program words before or between fetches. The block sits between the fetch unit and the decode stage in the multi-cycle CPU.

## Interface
- ADDR_W, 10: word-address bits implemented; memory depth is 2^ADDR_W words.
- LATENCY, 2: wait states from request accept to response valid; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  30  word address, the fetch unit's PC with the two low zero bits dropped.
- rsp_valid  out  1  response word available.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_data  out  32  instruction word.
- rsp_err  out  1  address out of range; qualified by rsp_valid.
- load_en  in  1  write load_data to load_addr this edge.
- load_addr  in  ADDR_W  load word address.
- load_data  in  32  load word.

## Operation
- States: IDLE, WAIT, RESP.
- Request handshake: the request is accepted on the edge where req_valid && req_ready. At acceptance, the block registers req_addr and sets cnt <= LATENCY-1.
- req_ready = rst_n && !load_en && (state==IDLE || (state==RESP && rsp_ready)). It is combinational, and req_addr is registered only at acceptance.
- IDLE: on accept, go to WAIT.
- WAIT, cnt != 0: cnt decrements.
- WAIT, cnt == 0: on this edge the block registers rsp_data and rsp_err and moves to RESP.
  - rsp_err = |addr[29:ADDR_W].
  - rsp_data = 0 if rsp_err, else mem[addr[ADDR_W-1:0]].
- RESP: rsp_valid = 1. rsp_data and rsp_err hold stable until rsp_valid && rsp_ready.
  - On that edge, a simultaneous accept goes to WAIT; otherwise the state returns to IDLE.
- Load:
  - load_en writes the memory on the edge and blocks request acceptance during that cycle.
  - Loads are legal in any state.
  - A load to the captured address during WAIT, up to and including the final WAIT edge, is visible in the response. At the final WAIT edge, the response carries the word written on that same edge; the write is forwarded to the read.
- Memory contents are not reset.
- Request and response channels never drop data: the response is held indefinitely under rsp_ready = 0.

## Timing
- Reset values: state IDLE, cnt 0, rsp_valid 0, rsp_data 0, rsp_err 0. req_ready is 0 while rst_n is low.
- Latency: accept at edge N leads to rsp_valid high after edge N+LATENCY.
- Throughput with rsp_ready held high: one response per LATENCY+1 cycles (back-to-back via RESP→WAIT).
- Reset mid-operation: an in-flight request is discarded with no response. The memory array keeps its contents.
- Address wrap: none. Any req_addr ≥ 2^ADDR_W returns an error, never an aliased word.
- When load_en and req_valid are high in the same cycle, the load wins and the request waits.

## Structure
- Shared header fetch_defs.vh holds:
  - the state encodings (IDLE=0, WAIT=1, RESP=2);
  - WORD_W=32 and PC_W=30, used by both the fetch unit and this block.
- Sub-module instr_mem_array holds the 2^ADDR_W x 32 storage, with one synchronous write port and one asynchronous read port. Read-during-write forwarding is done in instr_mem_responder.
- instr_mem_responder contains the FSM, the wait counter, and the response registers.

## Test plan
- Reset with req_valid held high:
  - required: rsp_valid = 0, rsp_data = 0, and req_ready = 0 while rst_n = 0;
  - required: the first accept occurs on the first edge after release.
- Load mem[3] = 0x2008000C, then request addr 3 with LATENCY=2 and rsp_ready=1:
  - required: accept at edge N;
  - required: rsp_valid after edge N+2 with rsp_data = 0x2008000C and rsp_err = 0.
- Back-to-back: requests 0,1,2 with rsp_ready=1 and LATENCY=2:
  - required: responses every 3 cycles, in order, with data equal to the loaded words.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP:
  - required: rsp_data and rsp_valid stable and req_ready=0;
  - required: after rsp_ready rises, a pending request is accepted on the same edge.
- Out of range: with ADDR_W=10, request req_addr = 0x400:
  - required: response has rsp_err = 1 and rsp_data = 0.
- Load and reset during WAIT:
  - load mem[5] = 0xDEADBEEF while a request to 5 is in WAIT; required: response = 0xDEADBEEF;
  - assert rst_n in WAIT; required: no response appears and the state returns to IDLE.

Source files
------------

// File: rtl/instr_mem_responder_pkg.sv
// Shared fetch-side definitions: word widths and
// responder state encoding.
package instr_mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int PC_W   = 30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/instr_mem_array.sv
// Program storage: one synchronous write port,
// one asynchronous read port, contents not reset.
module instr_mem_array
  import instr_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: valid/ready request in,
// fixed wait states, registered instruction word out.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PC_W-1:0]   req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] rd_data;
  logic              accept;
  logic              oor;
  logic              hit;

  instr_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (load_en),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (addr_q[ADDR_W-1:0]),
    .rdata_o (rd_data)
  );

  assign accept = req_valid && req_ready;
  assign oor    = |addr_q[PC_W-1:ADDR_W];
  // a load landing on the final wait edge must reach the response
  assign hit    = load_en &&
                  (load_addr == addr_q[ADDR_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    if (accept) begin
      addr_d = req_addr;
      cnt_d  = CNT_INIT;
    end
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          err_d   = oor;
          if (oor)      data_d = '0;
          else if (hit) data_d = load_data;
          else          data_d = rd_data;
        end
      end
      RESP: begin
        if (rsp_ready)
          state_d = accept ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst_n && !load_en &&
                (state_q == IDLE ||
                 (state_q == RESP && rsp_ready));
    rsp_valid = (state_q == RESP);
    rsp_data  = data_q;
    rsp_err   = err_q;
  end

endmodule
